// File: rtl/argmax_layer_pkg.sv
// Shared fixed-point definitions for the network layers, plus the argmax FSM states.
package argmax_layer_pkg;

  localparam int INTEGER_WIDTH  = 8;
  localparam int FRACTION_WIDTH = 8;

  typedef logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] fixed_t;

  typedef enum logic [1:0] {
    ACT_LINEAR,
    ACT_RELU,
    ACT_SIGMOID
  } activation_type;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } argmax_state_t;

endpackage

// File: rtl/argmax_layer.sv
// Classification stage: snapshots all scores on a rising inputs_ready, scans them one per
// cycle and reports the index and value of the largest signed score.
module argmax_layer
  import argmax_layer_pkg::*;
#(
  parameter int NUM_INPUTS  = 10,
  parameter int INDEX_WIDTH = $clog2(NUM_INPUTS)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   inputs_ready,
  input  fixed_t                 inputs [NUM_INPUTS],
  output logic                   outputs_ready,
  output logic [INDEX_WIDTH-1:0] max_index,
  output fixed_t                 max_value,
  output logic                   busy
);

  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(NUM_INPUTS - 1);
  localparam logic [INDEX_WIDTH-1:0] ONE        = INDEX_WIDTH'(1);

  argmax_state_t          state_q, state_d;
  logic                   inputs_ready_q;
  logic                   start;
  fixed_t                 buffer_q [NUM_INPUTS];
  fixed_t                 buffer_d [NUM_INPUTS];
  fixed_t                 best_value_q, best_value_d;
  logic [INDEX_WIDTH-1:0] best_index_q, best_index_d;
  logic [INDEX_WIDTH-1:0] counter_q, counter_d;
  logic                   publish_q, publish_d;
  logic                   outputs_ready_q, outputs_ready_d;
  logic [INDEX_WIDTH-1:0] max_index_q, max_index_d;
  fixed_t                 max_value_q, max_value_d;
  logic                   busy_q, busy_d;

  // A level held high only counts once; edges arriving mid-scan are swallowed here too.
  assign start = inputs_ready && !inputs_ready_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start) state_d = SCAN;
      SCAN:       if (counter_q == LAST_INDEX) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Results are published on the first cycle spent in DONE, one cycle after the last compare.
  always_comb begin
    buffer_d        = buffer_q;
    best_value_d    = best_value_q;
    best_index_d    = best_index_q;
    counter_d       = counter_q;
    publish_d       = publish_q;
    outputs_ready_d = outputs_ready_q;
    max_index_d     = max_index_q;
    max_value_d     = max_value_q;
    busy_d          = busy_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          buffer_d        = inputs;
          best_value_d    = inputs[0];
          best_index_d    = '0;
          counter_d       = ONE;
          publish_d       = 1'b0;
          outputs_ready_d = 1'b0;
          busy_d          = 1'b1;
        end else if (publish_q) begin
          max_index_d     = best_index_q;
          max_value_d     = best_value_q;
          outputs_ready_d = 1'b1;
          busy_d          = 1'b0;
          publish_d       = 1'b0;
        end
      end
      SCAN: begin
        if (buffer_q[counter_q] > best_value_q) begin
          best_value_d = buffer_q[counter_q];
          best_index_d = counter_q;
        end
        counter_d = counter_q + ONE;
        if (counter_q == LAST_INDEX) publish_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      inputs_ready_q  <= 1'b0;
      for (int i = 0; i < NUM_INPUTS; i++) buffer_q[i] <= '0;
      best_value_q    <= '0;
      best_index_q    <= '0;
      counter_q       <= '0;
      publish_q       <= 1'b0;
      outputs_ready_q <= 1'b0;
      max_index_q     <= '0;
      max_value_q     <= '0;
      busy_q          <= 1'b0;
    end else begin
      inputs_ready_q  <= inputs_ready;
      buffer_q        <= buffer_d;
      best_value_q    <= best_value_d;
      best_index_q    <= best_index_d;
      counter_q       <= counter_d;
      publish_q       <= publish_d;
      outputs_ready_q <= outputs_ready_d;
      max_index_q     <= max_index_d;
      max_value_q     <= max_value_d;
      busy_q          <= busy_d;
    end
  end

  assign outputs_ready = outputs_ready_q;
  assign max_index     = max_index_q;
  assign max_value     = max_value_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_argmax_layer.sv
// Self-checking bench for argmax_layer: directed scenarios plus randomized scores and a
// behavioural ReLU dense-layer model feeding the argmax stage.
module tb_argmax_layer;
  import argmax_layer_pkg::*;

  localparam int NUM = 10;
  localparam int IW  = $clog2(NUM);
  localparam int DENSE_IN = 16;

  typedef fixed_t score_t [NUM];

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          inputs_ready = 1'b0;
  fixed_t        inputs [NUM];
  logic          outputs_ready;
  logic [IW-1:0] max_index;
  fixed_t        max_value;
  logic          busy;

  int tests_run    = 0;
  int tests_failed = 0;

  argmax_layer #(.NUM_INPUTS(NUM)) dut (
    .clock(clock),
    .reset(reset),
    .inputs_ready(inputs_ready),
    .inputs(inputs),
    .outputs_ready(outputs_ready),
    .max_index(max_index),
    .max_value(max_value),
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Largest score first, then the first position holding it.
  function automatic void ref_argmax(input score_t s, output int idx, output int val);
    int m;
    m = int'(s[0]);
    foreach (s[i]) if (int'(s[i]) > m) m = int'(s[i]);
    idx = -1;
    foreach (s[i]) if (idx < 0 && int'(s[i]) == m) idx = i;
    val = m;
  endfunction

  task automatic start_and_wait(input score_t s, output int latency);
    inputs = s;
    inputs_ready = 1'b0;
    tick();
    inputs_ready = 1'b1;
    latency = -1;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (outputs_ready === 1'b1) begin
        latency = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    score_t s;
    foreach (s[i]) s[i] = fixed_t'(i * 100);
    inputs = s;
    reset = 1'b0;
    inputs_ready = 1'b1;
    repeat (3) tick();
    tests_run++;
    if (outputs_ready !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: got ready=%b busy=%b expected 0 0", outputs_ready, busy);
    end
    tests_run++;
    if (max_index !== '0 || max_value !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_result: got idx=%0d val=%0d expected 0 0", max_index, max_value);
    end
    inputs_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic_max();
    score_t s;
    int busy_err = 0;
    int rdy_err = 0;
    foreach (s[i]) s[i] = fixed_t'(64);
    s[7] = fixed_t'(384);
    inputs = s;
    inputs_ready = 1'b0;
    tick();
    inputs_ready = 1'b1;
    for (int k = 0; k <= NUM; k++) begin
      tick();
      if (busy !== (k < NUM)) busy_err++;
      if (outputs_ready !== (k == NUM)) rdy_err++;
    end
    tests_run++;
    if (busy_err != 0) begin
      tests_failed++;
      $display("[TB] FAIL basic_busy: got %0d bad cycles expected 0", busy_err);
    end
    tests_run++;
    if (rdy_err != 0) begin
      tests_failed++;
      $display("[TB] FAIL basic_latency: got %0d bad cycles expected 0", rdy_err);
    end
    tests_run++;
    if (max_index !== IW'(7) || max_value !== fixed_t'(384)) begin
      tests_failed++;
      $display("[TB] FAIL basic_result: got idx=%0d val=%0d expected 7 384", max_index, max_value);
    end
  endtask

  task automatic test_ties_extremes();
    score_t s;
    int lat;
    int exp_idx [3] = '{3, 0, 9};
    for (int c = 0; c < 3; c++) begin
      foreach (s[i]) s[i] = '0;
      if (c == 0) begin
        s[3] = fixed_t'(512);
        s[8] = fixed_t'(512);
      end else if (c == 1) begin
        s[0] = fixed_t'(300);
      end else begin
        s[9] = fixed_t'(300);
      end
      start_and_wait(s, lat);
      tests_run++;
      if (lat != NUM || int'(max_index) != exp_idx[c]) begin
        tests_failed++;
        $display("[TB] FAIL ties_extremes_%0d: got idx=%0d lat=%0d expected idx=%0d lat=%0d",
                 c, max_index, lat, exp_idx[c], NUM);
      end
    end
  endtask

  task automatic test_all_negative();
    score_t s;
    int lat;
    foreach (s[i]) s[i] = fixed_t'(-1024 + 64 * i);
    s[0] = fixed_t'(16'sh8000);
    s[5] = fixed_t'(-128);
    start_and_wait(s, lat);
    tests_run++;
    if (lat != NUM || max_index !== IW'(5) || max_value !== fixed_t'(-128)) begin
      tests_failed++;
      $display("[TB] FAIL all_negative: got idx=%0d val=%0d lat=%0d expected 5 -128 %0d",
               max_index, max_value, lat, NUM);
    end
  endtask

  task automatic test_level_held();
    score_t a;
    score_t b;
    int lat;
    int stable = 0;
    foreach (a[i]) a[i] = fixed_t'($urandom_range(0, 200));
    a[6] = fixed_t'(1000);
    start_and_wait(a, lat);
    for (int k = 0; k < 30; k++) begin
      tick();
      if (outputs_ready === 1'b1 && busy === 1'b0 && max_index === IW'(6) &&
          max_value === fixed_t'(1000)) stable++;
    end
    tests_run++;
    if (lat != NUM || stable != 30) begin
      tests_failed++;
      $display("[TB] FAIL level_held: got lat=%0d stable=%0d expected %0d 30", lat, stable, NUM);
    end
    foreach (b[i]) b[i] = fixed_t'($urandom_range(0, 200));
    b[2] = fixed_t'(900);
    inputs = b;
    inputs_ready = 1'b0;
    tick();
    tests_run++;
    if (outputs_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL level_drop_keeps: got ready=%b expected 1", outputs_ready);
    end
    inputs_ready = 1'b1;
    tick();
    tests_run++;
    if (outputs_ready !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL level_restart: got ready=%b busy=%b expected 0 1", outputs_ready, busy);
    end
    lat = -1;
    for (int k = 1; k < 50; k++) begin
      tick();
      if (outputs_ready === 1'b1) begin
        lat = k;
        break;
      end
    end
    tests_run++;
    if (lat != NUM || max_index !== IW'(2) || max_value !== fixed_t'(900)) begin
      tests_failed++;
      $display("[TB] FAIL level_second: got idx=%0d val=%0d lat=%0d expected 2 900 %0d",
               max_index, max_value, lat, NUM);
    end
  endtask

  task automatic test_mid_scan_inputs();
    score_t a;
    score_t b;
    int lat;
    foreach (a[i]) a[i] = fixed_t'($urandom_range(0, 300));
    a[1] = fixed_t'(700);
    foreach (b[i]) b[i] = fixed_t'(-100);
    b[8] = fixed_t'(2000);
    inputs = a;
    inputs_ready = 1'b0;
    tick();
    inputs_ready = 1'b1;
    repeat (4) tick();
    inputs = b;
    inputs_ready = 1'b0;
    tick();
    inputs_ready = 1'b1;
    tick();
    lat = -1;
    for (int k = 6; k < 50; k++) begin
      tick();
      if (outputs_ready === 1'b1) begin
        lat = k;
        break;
      end
    end
    tests_run++;
    if (lat != NUM || max_index !== IW'(1) || max_value !== fixed_t'(700)) begin
      tests_failed++;
      $display("[TB] FAIL mid_scan_inputs: got idx=%0d val=%0d lat=%0d expected 1 700 %0d",
               max_index, max_value, lat, NUM);
    end
    repeat (3) tick();
    tests_run++;
    if (outputs_ready !== 1'b1 || max_index !== IW'(1)) begin
      tests_failed++;
      $display("[TB] FAIL mid_scan_no_retrigger: got ready=%b idx=%0d expected 1 1",
               outputs_ready, max_index);
    end
  endtask

  task automatic test_mid_scan_reset();
    score_t a;
    score_t c;
    int lat;
    int exp_idx;
    int exp_val;
    foreach (a[i]) a[i] = fixed_t'($urandom_range(0, 500));
    inputs = a;
    inputs_ready = 1'b0;
    tick();
    inputs_ready = 1'b1;
    repeat (5) tick();
    reset = 1'b0;
    tick();
    tests_run++;
    if (outputs_ready !== 1'b0 || busy !== 1'b0 || max_index !== '0 || max_value !== '0) begin
      tests_failed++;
      $display("[TB] FAIL mid_scan_reset: got ready=%b busy=%b idx=%0d val=%0d expected 0 0 0 0",
               outputs_ready, busy, max_index, max_value);
    end
    reset = 1'b1;
    inputs_ready = 1'b0;
    tick();
    foreach (c[i]) c[i] = fixed_t'($urandom);
    ref_argmax(c, exp_idx, exp_val);
    start_and_wait(c, lat);
    tests_run++;
    if (lat != NUM || int'(max_index) != exp_idx || max_value !== fixed_t'(exp_val)) begin
      tests_failed++;
      $display("[TB] FAIL after_reset: got idx=%0d val=%0d lat=%0d expected %0d %0d %0d",
               max_index, max_value, lat, exp_idx, exp_val, NUM);
    end
  endtask

  task automatic test_random();
    score_t s;
    int lat;
    int exp_idx;
    int exp_val;
    for (int it = 0; it < 20; it++) begin
      foreach (s[i]) begin
        case (it % 3)
          0:       s[i] = fixed_t'($urandom);
          1:       s[i] = fixed_t'(int'($urandom_range(0, 3)) * 256 - 512);
          default: s[i] = fixed_t'(-1 - int'($urandom_range(0, 32767)));
        endcase
      end
      ref_argmax(s, exp_idx, exp_val);
      start_and_wait(s, lat);
      tests_run++;
      if (lat != NUM || int'(max_index) != exp_idx || max_value !== fixed_t'(exp_val)) begin
        tests_failed++;
        $display("[TB] FAIL random_%0d: got idx=%0d val=%0d lat=%0d expected %0d %0d %0d",
                 it, max_index, max_value, lat, exp_idx, exp_val, NUM);
      end
    end
  endtask

  // Behavioural ReLU dense layer (16 inputs, 10 neurons) producing the argmax scores.
  task automatic test_back_to_back();
    int x [DENSE_IN];
    int w [NUM][DENSE_IN];
    int b [NUM];
    score_t s;
    int acc;
    int lat;
    int exp_idx;
    int exp_val;
    for (int it = 0; it < 5; it++) begin
      foreach (x[j]) x[j] = int'($urandom_range(0, 511)) - 256;
      for (int n = 0; n < NUM; n++) begin
        foreach (x[j]) w[n][j] = int'($urandom_range(0, 255)) - 128;
        b[n] = int'($urandom_range(0, 127)) - 64;
      end
      for (int n = 0; n < NUM; n++) begin
        acc = 0;
        foreach (x[j]) acc += w[n][j] * x[j];
        acc = (acc >>> FRACTION_WIDTH) + b[n];
        s[n] = fixed_t'((acc > 0) ? acc : 0);
      end
      ref_argmax(s, exp_idx, exp_val);
      start_and_wait(s, lat);
      tests_run++;
      if (lat != NUM || int'(max_index) != exp_idx || max_value !== fixed_t'(exp_val)) begin
        tests_failed++;
        $display("[TB] FAIL dense_%0d: got idx=%0d val=%0d lat=%0d expected %0d %0d %0d",
                 it, max_index, max_value, lat, exp_idx, exp_val, NUM);
      end
    end
  endtask

  initial begin
    foreach (inputs[i]) inputs[i] = '0;
    test_reset();
    test_basic_max();
    test_ties_extremes();
    test_all_negative();
    test_level_held();
    test_mid_scan_inputs();
    test_mid_scan_reset();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/argmax_layer.md
Name: argmax_layer

Overview:
- Output stage directly downstream of dense_layer; consumes the final layer's `outputs`/`outputs_ready` and produces the classification result.
- Captures all scores on a start event, then scans them serially, one per cycle.
- Reports the index of the largest signed fixed-point score and the score itself, with a ready flag.

Parameters:
- NUM_INPUTS, 10, number of scores (neurons of the preceding dense layer); must be >= 2.
- INDEX_WIDTH, $clog2(NUM_INPUTS), width of the result index (derived; do not override).

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- inputs_ready  input  1  upstream valid; may be held high as a level.
- inputs  input  NUM_INPUTS x [INTEGER_WIDTH-1:-FRACTION_WIDTH] signed  scores from dense_layer.
- outputs_ready  output  1  result valid.
- max_index  output  INDEX_WIDTH  index of largest score.
- max_value  output  [INTEGER_WIDTH-1:-FRACTION_WIDTH] signed  largest score.
- busy  output  1  high while capturing or scanning.

Behaviour:
- Clock and reset: one clock (`clock`). Reset is synchronous and active-low (`reset`==0 sampled at a clock edge).
- Reset values: state=IDLE, outputs_ready=0, max_index=0, max_value=0, busy=0, internal inputs_ready_q=0.
- Start event: a rising edge of inputs_ready (inputs_ready && !inputs_ready_q). A level held high does not retrigger.
- inputs_ready_q is registered every cycle, in all states.
- IDLE / DONE, on a start event:
  - latch all inputs into an internal buffer;
  - best_value=inputs[0], best_index=0, counter=1;
  - outputs_ready<=0, busy<=1; go to SCAN.
- SCAN, each cycle, compare buffer[counter] > best_value (signed, strict):
  - if greater, update best_value/best_index;
  - counter++;
  - when counter==NUM_INPUTS-1 (after that compare), go to DONE.
- DONE entry:
  - max_index/max_value <= best values (final compare included);
  - outputs_ready<=1, busy<=0.
  - outputs_ready and results stay stable until the next start event or reset.
- Latency: start edge sampled at cycle 0 → outputs_ready high at cycle NUM_INPUTS.
  - Capture is cycle 0; compares run cycles 1..NUM_INPUTS-1; DONE register update lands at cycle NUM_INPUTS.
- Ties: strict > comparison, so the lowest index among equal maxima wins.
- All-negative scores are handled by signed compare; the result is the least-negative score.
- Start event during SCAN: ignored. Buffer and counter are unaffected; inputs_ready_q still tracks, so the edge is consumed.
- Inputs changing after capture: no effect on the current result.
- Reset mid-SCAN: return to IDLE with reset values; partial result discarded.
- No arithmetic beyond compare; values pass through at the full fixed-point width with no saturation.

Decomposition:
- Shared package/include.svh supplies INTEGER_WIDTH, FRACTION_WIDTH and the fixed-point type; no new constants needed.
- Add an `argmax_state_t` enum (IDLE, SCAN, DONE) to the shared package alongside `activation_type`.
- No sub-module: a single FSM plus comparator is natural.
- The top-level network instantiates argmax_layer after the last dense_layer, wiring dense_layer.outputs_ready→inputs_ready and dense_layer.outputs→inputs.
- Bench uses the existing clock_generator.

Test Plan:
- Basic max: NUM_INPUTS=10, scores 0.25 everywhere except index 7 = 1.5 → outputs_ready rises exactly 10 cycles after the start edge; max_index=7, max_value=1.5; busy high during cycles 1..9.
- Tie and extremes: scores [2.0 at idx 3, 2.0 at idx 8, rest 0] → max_index=3. Max at idx 0 → 0. Max at idx 9 → 9.
- All negative: scores -4.0..-0.5 with -0.5 at index 5 → max_index=5, max_value=-0.5. Most-negative representable value at index 0 does not win.
- Level-held start: hold inputs_ready high for 30 cycles → exactly one scan. outputs_ready stays high with stable result. Dropping and re-raising inputs_ready with new scores (max idx 2) clears outputs_ready for one scan, then reports 2.
- Mid-scan disturbances:
  - change inputs and pulse inputs_ready low→high at cycle 4 → result reflects the original captured scores;
  - assert reset=0 at cycle 5 → next cycle outputs_ready=0, busy=0, max_index=0, max_value=0. A fresh start after reset release produces a correct result.
- Back-to-back with dense_layer: RELU dense_layer (16 inputs, 10 neurons) with random fractional inputs feeds argmax_layer. The reported index equals a bench-computed argmax of dense_layer.outputs (lowest index on ties).
